// File: rtl/fibonacci_main_pkg.sv
// Shared types for the Fibonacci source.
// Holds the default width and the sender state encoding.
package fibonacci_main_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    DONE
  } state_t;

endpackage

// File: rtl/fibonacci_main_hs4_sender.sv
// Four-phase request/acknowledge sequencer.
// Pulses taken when the consumer drops Ack after a transfer.
module hs4_sender
  import fibonacci_main_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   go,
  input  logic   last,
  input  logic   ack,
  output logic   req,
  output logic   taken,
  output state_t state
);

  state_t state_q;
  state_t state_d;

  // State register, synchronous reset to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and taken pulse; Go only matters in IDLE/DONE.
  always_comb begin
    state_d = state_q;
    taken   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = REQ;
      end
      REQ: begin
        if (ack) state_d = RELEASE;
      end
      RELEASE: begin
        if (!ack) begin
          taken   = 1'b1;
          state_d = last ? DONE : REQ;
        end
      end
      DONE: begin
        if (!go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req   = (state_q == REQ);
  assign state = state_q;

endmodule

// File: rtl/fibonacci_main.sv
// Fibonacci source on a four-phase output channel.
// Emits F0 up to the largest term that fits in DATA_W bits.
module fibonacci_main
  import fibonacci_main_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  output logic              io_Out_HS_Req,
  input  logic              io_Out_HS_Ack,
  output logic [DATA_W-1:0] io_Out_Data,
  input  logic              io_Go
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W:0]   b_q;
  logic [DATA_W:0]   b_d;

  logic   taken;
  state_t state;

  hs4_sender u_sender (
    .clock (clock),
    .reset (reset),
    .go    (io_Go),
    .last  (b_q[DATA_W]),
    .ack   (io_Out_HS_Ack),
    .req   (io_Out_HS_Req),
    .taken (taken),
    .state (state)
  );

  // Term registers; the extra b bit flags the end of the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      a_q <= '0;
      b_q <= (DATA_W+1)'(1);
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  // Clear while idle, step only on a completed non-final transfer.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state == IDLE) begin
      a_d = '0;
      b_d = (DATA_W+1)'(1);
    end else if (taken && !b_q[DATA_W]) begin
      a_d = b_q[DATA_W-1:0];
      b_d = {1'b0, a_q} + b_q;
    end
  end

  assign io_Out_Data = a_q;

endmodule

// File: tb/tb_fibonacci_main.sv
// Scoreboard bench for fibonacci_main.
// Expected terms come from plain Fibonacci arithmetic.
module tb_fibonacci_main;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         go;
  logic         ack = 1'b0;
  logic         req;
  logic [W-1:0] data;

  int tests  = 0;
  int fails  = 0;
  int n_xfer = 0;
  int q[$];
  int last_term;

  bit   ack_hold = 1'b0;
  bit   rand_ack = 1'b0;
  logic req_d1   = 1'b0;
  logic mon_prev = 1'b0;
  int   held     = 0;

  always #5 clock = ~clock;

  fibonacci_main #(.DATA_W(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_Out_HS_Req (req),
    .io_Out_HS_Ack (ack),
    .io_Out_Data   (data),
    .io_Go         (go)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_run();
    longint x = 0;
    longint y = 1;
    longint t;
    while (x <= (64'd1 << W) - 1) begin
      q.push_back(int'(x));
      last_term = int'(x);
      t = x + y;
      x = y;
      y = t;
    end
  endfunction

  // Consumer: Ack follows Req one cycle late, optionally stalled or jittered.
  always @(negedge clock) begin
    if (ack_hold) ack = 1'b0;
    else if (!rand_ack || $urandom_range(0, 1) == 1) ack = req_d1;
    req_d1 = req;
  end

  // Monitor: a rising Req is one transfer; Data must hold while Req is high.
  always @(posedge clock) begin
    #1;
    if (req === 1'b1 && mon_prev !== 1'b1) begin
      n_xfer++;
      if (q.size() == 0) check("unexpected_xfer", int'(data), -1);
      else check("xfer_data", int'(data), q.pop_front());
      held = int'(data);
    end else if (req === 1'b1) begin
      check("data_stable", int'(data), held);
    end
    mon_prev = req;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int c = 0;
    while (n_xfer < target && c < budget) begin
      step(1);
      c++;
    end
    check(name, n_xfer, target);
  endtask

  task automatic done_checks(input int base, input string tag);
    step(10);
    check({tag, "_req"}, int'(req), 0);
    check({tag, "_data"}, int'(data), last_term);
    check({tag, "_xfers"}, n_xfer, base + 14);
    check({tag, "_queue"}, q.size(), 0);
  endtask

  initial begin
    int base;
    reset = 1'b1;
    go    = 1'b0;
    step(3);
    check("reset_req", int'(req), 0);
    check("reset_data", int'(data), 0);
    reset = 1'b0;

    step(10);
    check("idle_req", int'(req), 0);
    check("idle_data", int'(data), 0);
    check("idle_xfers", n_xfer, 0);

    push_run();
    go   = 1'b1;
    base = n_xfer;
    wait_xfers(base + 5, 200, "reach_5th");
    ack_hold = 1'b1;
    repeat (20) begin
      step(1);
      check("stall_req", int'(req), 1);
      check("stall_data", int'(data), 3);
    end
    ack_hold = 1'b0;
    wait_xfers(base + 14, 400, "run1_end");
    done_checks(base, "run1");

    go = 1'b0;
    step(3);
    check("rearm_req", int'(req), 0);
    check("rearm_data", int'(data), 0);
    rand_ack = 1'b1;
    push_run();
    go   = 1'b1;
    base = n_xfer;
    wait_xfers(base + 14, 800, "run2_end");
    done_checks(base, "run2");

    go = 1'b0;
    step(3);
    rand_ack = 1'b0;
    push_run();
    go   = 1'b1;
    base = n_xfer;
    wait_xfers(base + 8, 200, "reach_8th");
    check("pre_rst_req", int'(req), 1);
    check("pre_rst_data", int'(data), 13);
    reset = 1'b1;
    q.delete();
    step(1);
    check("rst_req", int'(req), 0);
    check("rst_data", int'(data), 0);
    step(1);
    reset = 1'b0;
    push_run();
    base = n_xfer;
    wait_xfers(base + 14, 400, "run3_end");
    done_checks(base, "run3");

    go = 1'b0;
    step(3);
    rand_ack = 1'b1;
    push_run();
    go   = 1'b1;
    base = n_xfer;
    wait_xfers(base + 6, 400, "reach_6th");
    go = 1'b0;
    step($urandom_range(1, 4));
    go = 1'b1;
    wait_xfers(base + 14, 800, "run4_end");
    done_checks(base, "run4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
